bit_deframer: RTL

//  Receive-side counterpart of the transmit framer: takes the bit-serial stream leaving the

---
 rtl/bit_deframer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bit_deframer.sv
// Receive deframer: hunts for a sync word in a bit-serial stream and reassembles each
// following DATA_W-bit payload into a codeword behind a single-entry valid/ready buffer.
module bit_deframer #(
    parameter int unsigned          SYNC_W    = 8,
    parameter logic [SYNC_W-1:0]    SYNC_WORD = 8'hA5,
    parameter int unsigned          DATA_W    = 12,
    parameter int unsigned          TIMEOUT   = 64,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_bit,
    input  logic              i_rx_bit_valid,
    output logic [DATA_W-1:0] o_cw_data,
    output logic              o_cw_valid,
    input  logic              i_cw_ready,
    output logic              o_locked,
    output logic              o_overrun,
    output logic              o_sync_lost,
    output logic [CNT_W-1:0]  o_frame_count
);

    localparam int unsigned BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {StHunt, StPayload} state_e;

    state_e              r_state,       w_state_nxt;
    logic [SYNC_W-1:0]   r_sync_sh,     w_sync_sh_nxt;
    logic [DATA_W-1:0]   r_pay_sh,      w_pay_sh_nxt;
    logic [BC_W-1:0]     r_bit_cnt,     w_bit_cnt_nxt;
    logic [IDLE_W-1:0]   r_idle,        w_idle_nxt;
    logic [DATA_W-1:0]   r_cw_data,     w_cw_data_nxt;
    logic                r_cw_valid,    w_cw_valid_nxt;
    logic                r_overrun,     w_overrun_nxt;
    logic                r_sync_lost,   w_sync_lost_nxt;
    logic [CNT_W-1:0]    r_frame_count, w_frame_count_nxt;
    logic [SYNC_W-1:0]   w_sync_shift;

    assign w_sync_shift = {r_sync_sh[SYNC_W-2:0], i_rx_bit};

    always_comb begin
        w_state_nxt       = r_state;
        w_sync_sh_nxt     = r_sync_sh;
        w_pay_sh_nxt      = r_pay_sh;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_idle_nxt        = r_idle;
        w_cw_data_nxt     = r_cw_data;
        w_cw_valid_nxt    = r_cw_valid;
        w_overrun_nxt     = 1'b0;
        w_sync_lost_nxt   = 1'b0;
        w_frame_count_nxt = r_frame_count;

        if (r_cw_valid && i_cw_ready) begin
            w_cw_valid_nxt = 1'b0;
        end

        case (r_state)
            StHunt: begin
                if (i_rx_bit_valid) begin
                    w_sync_sh_nxt = w_sync_shift;
                    if (w_sync_shift == SYNC_WORD) begin
                        w_state_nxt   = StPayload;
                        w_bit_cnt_nxt = '0;
                        w_idle_nxt    = '0;
                    end
                end
            end
            StPayload: begin
                if (i_rx_bit_valid) begin
                    w_pay_sh_nxt  = {r_pay_sh[DATA_W-2:0], i_rx_bit};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_idle_nxt    = '0;
                    if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
                        // Buffer is free if empty or being drained this very cycle.
                        if (!r_cw_valid || i_cw_ready) begin
                            w_cw_data_nxt     = {r_pay_sh[DATA_W-2:0], i_rx_bit};
                            w_cw_valid_nxt    = 1'b1;
                            w_frame_count_nxt = r_frame_count + 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_state_nxt   = StHunt;
                        w_sync_sh_nxt = '0;
                        w_bit_cnt_nxt = '0;
                    end
                end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                    w_sync_lost_nxt = 1'b1;
                    w_state_nxt     = StHunt;
                    w_sync_sh_nxt   = '0;
                    w_bit_cnt_nxt   = '0;
                    w_idle_nxt      = '0;
                end else begin
                    w_idle_nxt = r_idle + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StHunt;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StHunt;
            r_sync_sh     <= '0;
            r_pay_sh      <= '0;
            r_bit_cnt     <= '0;
            r_idle        <= '0;
            r_cw_data     <= '0;
            r_cw_valid    <= 1'b0;
            r_overrun     <= 1'b0;
            r_sync_lost   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sync_sh     <= w_sync_sh_nxt;
            r_pay_sh      <= w_pay_sh_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_idle        <= w_idle_nxt;
            r_cw_data     <= w_cw_data_nxt;
            r_cw_valid    <= w_cw_valid_nxt;
            r_overrun     <= w_overrun_nxt;
            r_sync_lost   <= w_sync_lost_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign o_cw_data     = r_cw_data;
    assign o_cw_valid    = r_cw_valid;
    assign o_locked      = (r_state == StPayload);
    assign o_overrun     = r_overrun;
    assign o_sync_lost   = r_sync_lost;
    assign o_frame_count = r_frame_count;

endmodule
